// File: rtl/coeff_load_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : coeff_load_ctrl_if
// Description : Host access bus and BRAM port bundle for coeff_load_ctrl.
//               Host side: host_req/host_we/host_addr/host_wdata in,
//               host_gnt/host_rdata/host_rvalid out (w.r.t. the controller).
//               BRAM side: bram_addr/bram_we/bram_wdata out, bram_rdata in.
//               slave  : view used by the controller.
//               master : view used by the host / BRAM environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface coeff_load_ctrl_if;
    logic        host_req;
    logic        host_we;
    logic [5:0]  host_addr;
    logic [31:0] host_wdata;
    logic        host_gnt;
    logic [31:0] host_rdata;
    logic        host_rvalid;
    logic [5:0]  bram_addr;
    logic        bram_we;
    logic [31:0] bram_wdata;
    logic [31:0] bram_rdata;

    modport slave (
        input  host_req, host_we, host_addr, host_wdata, bram_rdata,
        output host_gnt, host_rdata, host_rvalid, bram_addr, bram_we, bram_wdata
    );

    modport master (
        output host_req, host_we, host_addr, host_wdata, bram_rdata,
        input  host_gnt, host_rdata, host_rvalid, bram_addr, bram_we, bram_wdata
    );
endinterface
`default_nettype wire

// File: rtl/coeff_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : coeff_load_ctrl
// Description : On each rising edge of vs_i, fetches 25 signed 16-bit
//               coefficients (BRAM words 0..24, low half) into a shadow
//               store and publishes them atomically on coeff_flat with a
//               one-cycle coeff_upd pulse. Between fetches a host may read
//               or write any BRAM word through the same single port.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               vs_i            - vertical sync, rising edge starts a fetch
//               bus (slave)     - host request/grant bus and BRAM port
//               coeff_flat      - active 5x5 set, coeff k at [16k+15:16k]
//               coeff_upd       - pulse in first cycle of a new set
//               busy            - fetch sequence in progress
//               overrun         - sticky: sync edge seen while busy
// Revision    : 1.0 - initial release
// ============================================================================
module coeff_load_ctrl (
    input  logic             clk,
    input  logic             rst,
    input  logic             vs_i,
    coeff_load_ctrl_if.slave bus,
    output logic [399:0]     coeff_flat,
    output logic             coeff_upd,
    output logic             busy,
    output logic             overrun
);

    localparam int c_NUM_COEFF = 25;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_DRAIN  = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic        r_vs_dly;
    logic        r_cap_vld;
    logic [4:0]  r_cap_idx;
    logic        r_rvalid;
    logic [15:0] r_shadow [c_NUM_COEFF];

    logic        w_edge;
    logic        w_gnt;
    logic        w_fetch;
    logic [15:0] w_shadow_nxt [c_NUM_COEFF];
    logic [399:0] w_flat_nxt;

    assign w_edge  = vs_i & ~r_vs_dly;
    // The fetch owns the port from the edge cycle on; a waiting host
    // request simply stays pending until the controller is idle again.
    assign w_gnt   = ~rst & (r_state == S_IDLE) & ~w_edge & bus.host_req;
    assign w_fetch = ~rst & (r_state == S_FETCH);

    assign busy            = (r_state != S_IDLE);
    assign bus.host_gnt    = w_gnt;
    assign bus.host_rvalid = r_rvalid;
    // BRAM has one cycle of read latency, so read data is passed straight
    // through in the cycle after the grant.
    assign bus.host_rdata  = r_rvalid ? bus.bram_rdata : 32'd0;

    always_comb begin
        bus.bram_addr  = 6'd0;
        bus.bram_we    = 1'b0;
        bus.bram_wdata = 32'd0;
        if (w_fetch) begin
            bus.bram_addr = {1'b0, r_cnt};
        end else if (w_gnt) begin
            bus.bram_addr  = bus.host_addr;
            bus.bram_we    = bus.host_we;
            bus.bram_wdata = bus.host_wdata;
        end
    end

    // Shadow contents including the word returning this cycle; lets the
    // DRAIN cycle publish slot 24 together with the rest of the set.
    always_comb begin
        w_flat_nxt = '0;
        for (int k = 0; k < c_NUM_COEFF; k++) begin
            w_shadow_nxt[k] = r_shadow[k];
            if (r_cap_vld && (r_cap_idx == 5'(k))) begin
                w_shadow_nxt[k] = bus.bram_rdata[15:0];
            end
            w_flat_nxt[16*k +: 16] = w_shadow_nxt[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 5'd0;
            r_vs_dly   <= 1'b1;
            r_cap_vld  <= 1'b0;
            r_cap_idx  <= 5'd0;
            r_rvalid   <= 1'b0;
            coeff_flat <= '0;
            coeff_upd  <= 1'b0;
            overrun    <= 1'b0;
            for (int k = 0; k < c_NUM_COEFF; k++) begin
                r_shadow[k] <= 16'd0;
            end
        end else begin
            r_vs_dly  <= vs_i;
            r_rvalid  <= w_gnt & ~bus.host_we;
            r_cap_vld <= 1'b0;
            coeff_upd <= 1'b0;
            for (int k = 0; k < c_NUM_COEFF; k++) begin
                r_shadow[k] <= w_shadow_nxt[k];
            end
            // Edges while a fetch is in flight are dropped, only flagged.
            if (w_edge && (r_state != S_IDLE)) begin
                overrun <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_edge) begin
                        r_state <= S_FETCH;
                        r_cnt   <= 5'd0;
                    end
                end
                S_FETCH: begin
                    r_cap_vld <= 1'b1;
                    r_cap_idx <= r_cnt;
                    r_cnt     <= r_cnt + 5'd1;
                    if (r_cnt == 5'(c_NUM_COEFF - 1)) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Register load here so the new set and its pulse are
                    // visible during the COMMIT cycle.
                    coeff_flat <= w_flat_nxt;
                    coeff_upd  <= 1'b1;
                    r_state    <= S_COMMIT;
                end
                S_COMMIT: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/coeff_load_ctrl.md
COEFF_LOAD_CTRL -- requirements
Module: coeff_load_ctrl

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 vs_i  in  1  video vertical sync; rising edge triggers a coefficient fetch.
REQ-004 host_req  in  1  host access request; host holds it until host_gnt.
REQ-005 host_we  in  1  1 = write, 0 = read; qualified by host_req.
REQ-006 host_addr  in  6  host BRAM word address.
REQ-007 host_wdata  in  32  host write data.
REQ-008 host_gnt  out  1  one-cycle grant; access is executed on the BRAM port in the same cycle.
REQ-009 host_rdata  out  32  read data; valid only when host_rvalid=1.
REQ-010 host_rvalid  out  1  one-cycle pulse, exactly 1 cycle after a granted read.
REQ-011 bram_addr  out  6  BRAM port address.
REQ-012 bram_we  out  1  BRAM write enable.
REQ-013 bram_wdata  out  32  BRAM write data.
REQ-014 bram_rdata  in  32  BRAM read data; 1-cycle read latency.
REQ-015 coeff_flat  out  400  active 5x5 coefficients; coeff k (k=0..24, row-major) at bits [16k+15:16k], signed 16-bit, taken from bram_rdata[15:0].
REQ-016 coeff_upd  out  1  one-cycle pulse in the first cycle coeff_flat carries a new set.
REQ-017 busy  out  1  1 while state is not IDLE.
REQ-018 overrun  out  1  sticky flag: vs_i edge arrived while not IDLE.

Function
REQ-019 The block SHALL register vs_i into vs_dly each cycle; edge = vs_i & ~vs_dly.
REQ-020 The state machine SHALL have states IDLE, FETCH, DRAIN, COMMIT.
REQ-021 IDLE -> FETCH on edge; fetch counter cleared to 0.
REQ-022 In FETCH, the block SHALL drive bram_addr = counter, bram_we = 0, and increment the counter each cycle; after issuing address 24 -> DRAIN.
REQ-023 Data returned for address k (one cycle after issue) SHALL be written to shadow slot k; DRAIN captures slot 24.
REQ-024 DRAIN -> COMMIT unconditionally; COMMIT copies all 25 shadow slots to coeff_flat at once, asserts coeff_upd, -> IDLE.
REQ-025 Timing: with the edge visible in cycle t, addresses 0..24 are issued in t+1..t+25, and coeff_flat/coeff_upd update in t+27.
REQ-026 coeff_flat SHALL never show a partially loaded set; the shadow is not visible externally.
REQ-027 Host accesses SHALL be granted only in IDLE with no edge in the same cycle; the fetch has priority and the host request stays pending.
REQ-028 On grant, bram_addr = host_addr, bram_we = host_we, bram_wdata = host_wdata; at most one grant per cycle, back-to-back grants allowed.
REQ-029 After a granted read, host_rdata = bram_rdata and host_rvalid = 1 in the next cycle, even if a fetch has started.
REQ-030 A host write to addresses 0..24 SHALL NOT change coeff_flat until the next completed fetch.
REQ-031 Host addresses 25..63 SHALL be accessed normally and never enter coeff_flat.
REQ-032 An edge in FETCH, DRAIN or COMMIT SHALL be ignored (no restart, no queuing) and set overrun.
REQ-033 When no access is granted and not in FETCH, bram_we SHALL be 0 and bram_addr SHALL be 0.

Reset
REQ-034 On rst: state IDLE, counter 0, vs_dly 1 (no spurious edge at release), shadow and coeff_flat all 0, coeff_upd/host_gnt/host_rvalid/busy/overrun/bram_we 0, bram_addr 0, host_rdata 0, bram_wdata 0.
REQ-035 rst during FETCH/DRAIN SHALL abort the fetch with no commit; coeff_flat reads 0 the next cycle.

Verification
REQ-036 BRAM word k = k+1, vs_i 0->1 at cycle t -> addresses 0..24 on t+1..t+25, coeff_upd in t+27, coeff k = k+1, busy high t+1..t+27.
REQ-037 host_req write addr 3 data 0x0000_FFF0 in the same cycle as the edge -> no grant until the fetch ends, grant in t+28, coeff 3 unchanged until the next fetch, which yields -16.
REQ-038 Host read of addr 40 in IDLE -> grant in that cycle, host_rvalid plus data 1 cycle later, coeff_flat unchanged.
REQ-039 Second vs_i edge at t+10 -> no restart, single coeff_upd at t+27, overrun = 1 until rst.
REQ-040 rst asserted at t+12 of a fetch -> coeff_flat 0, no coeff_upd, IDLE; vs_i held high through rst release -> no fetch.
